// File: rtl/serial_io_pkg.sv
// Shared constants and FSM encoding for the serial LED/switch command controller.
package serial_io_pkg;

  // Command bytes accepted from the host
  localparam logic [7:0] CMD_LED      = 8'h4C;  // 'L' + one argument byte
  localparam logic [7:0] CMD_READ_LED = 8'h52;  // 'R'
  localparam logic [7:0] CMD_SWITCH   = 8'h53;  // 'S'

  // Fixed reply bytes
  localparam logic [7:0] RSP_OK  = 8'h4B;       // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;       // '?'

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ARG  = 3'd1,
    ST_SEND      = 3'd2,
    ST_HOLD      = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  // True while a reply is pending or on the wire; new rx bytes are dropped here
  function automatic logic in_reply_phase(input state_e s);
    return (s == ST_SEND) || (s == ST_HOLD) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability filter chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_io_ctrl.sv
// Decodes host commands from uart_rx, drives the LED register, samples switches
// and schedules exactly one reply byte on uart_tx per accepted command.
module serial_io_ctrl
  import serial_io_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 6,
  parameter int unsigned NUM_SWITCHES   = 6,
  parameter int unsigned ACTIVE_LOW     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    tx_busy,
  output logic                    tx_en,
  output logic [7:0]              tx_data,
  output logic [NUM_LEDS-1:0]     leds_out,
  input  logic [NUM_SWITCHES-1:0] switches_in,
  output logic                    cmd_err,
  output logic                    rx_overrun
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0]     LED_POL = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_SWITCHES-1:0] SW_POL  = (ACTIVE_LOW != 0) ? '1 : '0;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_LEDS-1:0]     led_q, led_d;
  logic [NUM_LEDS-1:0]     leds_q;
  logic                    tx_en_q, tx_en_d;
  logic [BYTE_W-1:0]       tx_data_q, tx_data_d;
  logic                    cmd_err_q, cmd_err_d;
  logic                    rx_overrun_q, rx_overrun_d;
  logic [NUM_SWITCHES-1:0] sw_sync;
  logic [NUM_SWITCHES-1:0] sw_logic;
  logic                    tmo_hit;

  sync_2ff #(
    .WIDTH(NUM_SWITCHES)
  ) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d_i (switches_in),
    .q_o (sw_sync)
  );

  // Board polarity removed after synchronisation
  assign sw_logic = sw_sync ^ SW_POL;
  assign tmo_hit  = (cnt_q == TMO_LAST);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          state_d = (rx_data == CMD_LED) ? ST_WAIT_ARG : ST_SEND;
        end
      end
      ST_WAIT_ARG: begin
        if (rx_valid) begin
          state_d = ST_SEND;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // tx_en_q high means the start pulse is on the wire this cycle
        if (tx_en_q) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values for registered outputs, LED register and timeout counter
  always_comb begin
    cnt_d        = cnt_q;
    led_d        = led_q;
    tx_data_d    = tx_data_q;
    cmd_err_d    = 1'b0;
    rx_overrun_d = 1'b0;
    tx_en_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_LED:      cnt_d     = '0;
            CMD_READ_LED: tx_data_d = BYTE_W'(led_q);
            CMD_SWITCH:   tx_data_d = BYTE_W'(sw_logic);
            default: begin
              tx_data_d = RSP_ERR;
              cmd_err_d = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT_ARG: begin
        if (rx_valid) begin
          led_d     = rx_data[NUM_LEDS-1:0];
          tx_data_d = RSP_OK;
        end else if (tmo_hit) begin
          cmd_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        rx_overrun_d = rx_valid && in_reply_phase(state_q);
      end
    endcase

    // Start pulse registered so it appears the cycle after the reply is latched
    tx_en_d = (state_d == ST_SEND) && !tx_busy;
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      led_q        <= '0;
      leds_q       <= LED_POL;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      cmd_err_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      led_q        <= led_d;
      leds_q       <= led_d ^ LED_POL;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      cmd_err_q    <= cmd_err_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign leds_out   = leds_q;
  assign cmd_err    = cmd_err_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_serial_io_ctrl.sv
// Bench for serial_io_ctrl: uart_tx busy model, event monitor and a command-level reference model.
module tb_serial_io_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [5:0] leds_out;
  logic [5:0] switches_in = 6'h3F;
  logic       cmd_err;
  logic       rx_overrun;

  int checks = 0;
  int failures = 0;

  // uart_tx behaviour: busy rises the cycle after tx_en, lasts frame_len cycles
  logic force_busy = 1'b0;
  int   frame_len = 8;
  int   busy_cnt = 0;

  // Monitor state
  logic [7:0] txq[$];
  int tx_cnt = 0, err_cnt = 0, ovr_cnt = 0, cyc = 0, err_cyc = 0;

  // Reference model: logical LED register contents
  logic [5:0] led_model = 6'h00;

  serial_io_ctrl #(
    .NUM_LEDS      (6),
    .NUM_SWITCHES  (6),
    .ACTIVE_LOW    (1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .leds_out   (leds_out),
    .switches_in(switches_in),
    .cmd_err    (cmd_err),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_en) busy_cnt <= frame_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  // Sample DUT outputs on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (tx_en) begin
      txq.push_back(tx_data);
      tx_cnt++;
    end
    if (cmd_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (rx_overrun) ovr_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_reply(input logic [7:0] cmd);
    case (cmd)
      8'h4C:   return 8'h4B;
      8'h52:   return {2'b00, led_model};
      8'h53:   return {2'b00, ~switches_in};
      default: return 8'h3F;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    txq.delete();
    tx_cnt = 0;
    err_cnt = 0;
    ovr_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    step();
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  // Waits (bounded) for a reply byte; returns X when none arrives
  task automatic wait_tx(output logic [7:0] got);
    int n = 0;
    while (txq.size() == 0 && n < 200) begin
      step();
      n++;
    end
    got = (txq.size() != 0) ? txq.pop_front() : 8'hxx;
  endtask

  task automatic wait_idle();
    int n = 0;
    step();
    step();
    while (tx_busy && n < 300) begin
      step();
      n++;
    end
    repeat (3) step();
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input bit has_arg, input logic [7:0] arg,
                         output logic [7:0] got);
    clear_mon();
    send_byte(cmd);
    if (has_arg) send_byte(arg);
    wait_tx(got);
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({tx_en, cmd_err, rx_overrun} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses: tx_en/cmd_err/rx_overrun=%b required 000", {tx_en, cmd_err, rx_overrun});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx_data: got %h required 00", tx_data);
    end
    checks++;
    if (leds_out !== 6'h3F) begin
      failures++;
      $display("FAIL reset_leds: got %b required 111111", leds_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_led();
    logic [7:0] got, arg;
    run_cmd(8'h4C, 1'b1, 8'h15, got);
    led_model = 6'h15;
    checks++;
    if (got !== 8'h4B) begin
      failures++;
      $display("FAIL led_reply: got %h required 4b", got);
    end
    checks++;
    if (leds_out !== 6'b101010) begin
      failures++;
      $display("FAIL led_pins: got %b required 101010", leds_out);
    end
    checks++;
    if (tx_cnt !== 1 || err_cnt !== 0) begin
      failures++;
      $display("FAIL led_counts: tx_en=%0d cmd_err=%0d required 1 and 0", tx_cnt, err_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      arg = 8'($urandom);
      run_cmd(8'h4C, 1'b1, arg, got);
      led_model = arg[5:0];
      checks++;
      if (leds_out !== ~led_model) begin
        failures++;
        $display("FAIL led_rand_pins: arg %h got %b required %b", arg, leds_out, ~led_model);
      end
      run_cmd(8'h52, 1'b0, 8'h00, got);
      checks++;
      if (got !== model_reply(8'h52) || tx_cnt !== 1) begin
        failures++;
        $display("FAIL led_readback: got %h (tx_en=%0d) required %h (1)", got, tx_cnt, model_reply(8'h52));
      end
    end
  endtask

  task automatic test_switch();
    logic [7:0] got;
    switches_in = 6'b110100;
    repeat (4) step();
    run_cmd(8'h53, 1'b0, 8'h00, got);
    checks++;
    if (got !== 8'h0B) begin
      failures++;
      $display("FAIL switch_reply: got %h required 0b", got);
    end
    checks++;
    if (tx_cnt !== 1 || err_cnt !== 0) begin
      failures++;
      $display("FAIL switch_counts: tx_en=%0d cmd_err=%0d required 1 and 0", tx_cnt, err_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      switches_in = 6'($urandom);
      repeat (4) step();
      run_cmd(8'h53, 1'b0, 8'h00, got);
      checks++;
      if (got !== model_reply(8'h53)) begin
        failures++;
        $display("FAIL switch_rand: pins %b got %h required %h", switches_in, got, model_reply(8'h53));
      end
    end
  endtask

  task automatic test_unknown();
    logic [7:0] got, b;
    run_cmd(8'h41, 1'b0, 8'h00, got);
    checks++;
    if (got !== 8'h3F || err_cnt !== 1 || tx_cnt !== 1) begin
      failures++;
      $display("FAIL unknown_41: reply %h cmd_err=%0d tx_en=%0d required 3f 1 1", got, err_cnt, tx_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      while (b == 8'h4C || b == 8'h52 || b == 8'h53) b = 8'($urandom);
      run_cmd(b, 1'b0, 8'h00, got);
      checks++;
      if (got !== 8'h3F || err_cnt !== 1) begin
        failures++;
        $display("FAIL unknown_rand: byte %h reply %h cmd_err=%0d required 3f 1", b, got, err_cnt);
      end
    end
    run_cmd(8'h52, 1'b0, 8'h00, got);
    checks++;
    if (got !== model_reply(8'h52) || err_cnt !== 0) begin
      failures++;
      $display("FAIL unknown_recover: reply %h cmd_err=%0d required %h 0", got, err_cnt, model_reply(8'h52));
    end
  endtask

  task automatic test_timeout();
    logic [7:0] got;
    logic [5:0] leds_before;
    int c0, dly;
    leds_before = leds_out;
    clear_mon();
    send_byte(8'h4C);
    c0 = cyc;
    repeat (24) step();
    dly = err_cyc - c0;
    checks++;
    if (err_cnt !== 1 || dly < 15 || dly > 17) begin
      failures++;
      $display("FAIL timeout_err: cmd_err pulses=%0d delay=%0d required 1 pulse at 15..17", err_cnt, dly);
    end
    checks++;
    if (tx_cnt !== 0 || leds_out !== leds_before) begin
      failures++;
      $display("FAIL timeout_quiet: tx_en=%0d leds=%b required 0 and %b", tx_cnt, leds_out, leds_before);
    end
    // Next byte must be decoded as a fresh command, not as the LED argument
    run_cmd(8'h52, 1'b0, 8'h00, got);
    checks++;
    if (got !== model_reply(8'h52)) begin
      failures++;
      $display("FAIL timeout_idle: reply %h required %h", got, model_reply(8'h52));
    end
  endtask

  task automatic test_busy_hold();
    logic [7:0] got;
    force_busy = 1'b1;
    clear_mon();
    send_byte(8'h52);
    repeat (4) step();
    send_byte(8'h53);
    repeat (6) step();
    checks++;
    if (tx_cnt !== 0 || ovr_cnt !== 1) begin
      failures++;
      $display("FAIL busy_wait: tx_en=%0d rx_overrun=%0d required 0 and 1", tx_cnt, ovr_cnt);
    end
    frame_len = 20;
    force_busy = 1'b0;
    wait_tx(got);
    checks++;
    if (got !== model_reply(8'h52)) begin
      failures++;
      $display("FAIL busy_reply: got %h required %h", got, model_reply(8'h52));
    end
    repeat (3) step();
    send_byte(8'h41);
    wait_idle();
    checks++;
    if (ovr_cnt !== 2 || tx_cnt !== 1 || err_cnt !== 0) begin
      failures++;
      $display("FAIL busy_overrun: rx_overrun=%0d tx_en=%0d cmd_err=%0d required 2 1 0", ovr_cnt, tx_cnt, err_cnt);
    end
    frame_len = 8;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    // Reset while waiting for the LED argument
    clear_mon();
    send_byte(8'h4C);
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({tx_en, cmd_err, rx_overrun} !== 3'b000 || tx_data !== 8'h00 || leds_out !== 6'h3F) begin
      failures++;
      $display("FAIL rst_wait_arg: tx_en/err/ovr=%b tx_data=%h leds=%b required 000 00 111111",
               {tx_en, cmd_err, rx_overrun}, tx_data, leds_out);
    end
    led_model = 6'h00;
    rst = 1'b0;
    step();
    run_cmd(8'h15, 1'b0, 8'h00, got);
    checks++;
    if (got !== 8'h3F || err_cnt !== 1) begin
      failures++;
      $display("FAIL rst_arg_as_cmd: reply %h cmd_err=%0d required 3f 1", got, err_cnt);
    end
    // Reset while the reply frame is still going out
    run_cmd(8'h4C, 1'b1, 8'h2A, got);
    led_model = 6'h2A;
    frame_len = 30;
    clear_mon();
    send_byte(8'h52);
    wait_tx(got);
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if ({tx_en, cmd_err, rx_overrun} !== 3'b000 || tx_data !== 8'h00 || leds_out !== 6'h3F) begin
      failures++;
      $display("FAIL rst_wait_done: tx_en/err/ovr=%b tx_data=%h leds=%b required 000 00 111111",
               {tx_en, cmd_err, rx_overrun}, tx_data, leds_out);
    end
    led_model = 6'h00;
    rst = 1'b0;
    clear_mon();
    send_byte(8'h52);
    repeat (4) step();
    checks++;
    if (!tx_busy || tx_cnt !== 0) begin
      failures++;
      $display("FAIL rst_busy_wait: busy=%b tx_en=%0d required 1 and 0", tx_busy, tx_cnt);
    end
    wait_tx(got);
    wait_idle();
    checks++;
    if (got !== 8'h00 || tx_cnt !== 1) begin
      failures++;
      $display("FAIL rst_after_reply: reply %h tx_en=%0d required 00 1", got, tx_cnt);
    end
    frame_len = 8;
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, cmd, arg, exp;
    bit exp_err;
    for (int i = 0; i < 20; i++) begin
      switches_in = 6'($urandom);
      frame_len = $urandom_range(2, 12);
      repeat (3) step();
      case ($urandom_range(0, 3))
        0: cmd = 8'h4C;
        1: cmd = 8'h52;
        2: cmd = 8'h53;
        default: begin
          cmd = 8'($urandom);
          while (cmd == 8'h4C || cmd == 8'h52 || cmd == 8'h53) cmd = 8'($urandom);
        end
      endcase
      arg = 8'($urandom);
      exp = model_reply(cmd);
      exp_err = !(cmd == 8'h4C || cmd == 8'h52 || cmd == 8'h53);
      run_cmd(cmd, cmd == 8'h4C, arg, got);
      if (cmd == 8'h4C) led_model = arg[5:0];
      checks++;
      if (got !== exp || tx_cnt !== 1) begin
        failures++;
        $display("FAIL b2b_reply: iter %0d cmd %h reply %h tx_en=%0d required %h 1", i, cmd, got, tx_cnt, exp);
      end
      checks++;
      if (err_cnt !== int'(exp_err) || ovr_cnt !== 0 || leds_out !== ~led_model) begin
        failures++;
        $display("FAIL b2b_side: iter %0d cmd %h cmd_err=%0d ovr=%0d leds=%b required %0d 0 %b",
                 i, cmd, err_cnt, ovr_cnt, leds_out, exp_err, ~led_model);
      end
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_switch();
    test_unknown();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
